seq_smul_nb: RTL and testbench

SEQ_SMUL_NB -- requirements
Module: seq_smul_nb

---
 rtl/seq_smul_pkg.sv | 11 +
 rtl/seq_smul_nb.sv | 112 +++++++++++
 tb/tb_seq_smul_nb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_smul_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Holds the controller state encoding.
package seq_smul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_smul_nb.sv
// Sequential signed/unsigned shift-add multiplier, valid/ready both sides.
// Optional early exit when the multiplier runs out: SEQ_SMUL_EARLY_TERM_EN.
module seq_smul_nb
  import seq_smul_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [NBITS-1:0]   in0,
  input  logic [NBITS-1:0]   in1,
  input  logic               is_signed,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [2*NBITS-1:0] out
);

  localparam int RW = 2 * NBITS;
  localparam int CW = $clog2(NBITS + 1);

  state_t           state;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [NBITS-1:0] mplr;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [NBITS-1:0] mag0;
  logic [NBITS-1:0] mag1;
  logic             neg_in;
  logic [RW-1:0]    acc_step;
  logic [NBITS-1:0] mplr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             last_step;
  logic [RW-1:0]    res;

  // Operand magnitudes and product sign at accept time.
  always_comb begin
    mag0   = in0;
    mag1   = in1;
    neg_in = 1'b0;
    if (is_signed) begin
      if (in0[NBITS-1])
        mag0 = ~in0 + NBITS'(1);
      if (in1[NBITS-1])
        mag1 = ~in1 + NBITS'(1);
      neg_in = in0[NBITS-1] ^ in1[NBITS-1];
    end
  end

  // One shift-add step and the exit test for it.
  always_comb begin
    acc_step = mplr[0] ? acc + mcand : acc;
    mplr_nxt = mplr >> 1;
    cnt_nxt  = cnt + CW'(1);
`ifdef SEQ_SMUL_EARLY_TERM_EN
    last_step = (cnt_nxt == CW'(NBITS)) ||
                (mplr_nxt == '0);
`else
    last_step = (cnt_nxt == CW'(NBITS));
`endif
  end

  // Handshake flags and sign-corrected product, decoded from state.
  always_comb begin
    in_rdy  = (state == IDLE);
    out_val = (state == DONE);
    res     = neg ? (~acc + RW'(1)) : acc;
    out     = (state == DONE) ? res : '0;
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_val) begin
            mcand <= {{NBITS{1'b0}}, mag0};
            mplr  <= mag1;
            neg   <= neg_in;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_step;
          mcand <= mcand << 1;
          mplr  <= mplr_nxt;
          cnt   <= cnt_nxt;
          if (last_step)
            state <= DONE;
        end
        DONE: begin
          if (out_rdy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_smul_nb.sv
// Directed and light random checks for seq_smul_nb at NBITS=8.
// Expected products and latencies are worked out in the bench.
module tb_seq_smul_nb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        is_signed;
  logic        out_val;
  logic        out_rdy;
  logic [15:0] out;

  int checks   = 0;
  int failures = 0;

  seq_smul_nb #(.NBITS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in0       (in0),
    .in1       (in1),
    .is_signed (is_signed),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b,
                                 input logic s);
    logic [7:0] m;
    int len;
    m = b;
    if (s && b[7]) m = 8'(-b);
    len = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) len = i + 1;
`ifdef SEQ_SMUL_EARLY_TERM_EN
    return (len == 0 ? 1 : len) + 1;
`else
    return 9;
`endif
  endfunction

  task automatic do_mul(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic s,
                        input logic [15:0] expv,
                        input int hold);
    int n;
    logic [15:0] held;
    @(negedge clk);
    chk({tag, ".in_rdy"}, 32'(in_rdy), 32'd1);
    in_val = 1'b1;
    in0 = a;
    in1 = b;
    is_signed = s;
    out_rdy = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_val = 1'b0;
    in0 = 8'($urandom);
    in1 = 8'($urandom);
    is_signed = 1'($urandom);
    while (!out_val && n < 64) begin
      chk({tag, ".busy_rdy"}, 32'(in_rdy), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat(b, s)));
    chk({tag, ".out"}, 32'(out), 32'(expv));
    held = out;
    for (int k = 0; k < hold; k++) begin
      in_val = 1'b1;
      in0 = 8'($urandom);
      in1 = 8'($urandom);
      @(negedge clk);
      chk({tag, ".hold_out"}, 32'(out), 32'(held));
      chk({tag, ".hold_val"}, 32'(out_val), 32'd1);
      chk({tag, ".hold_rdy"}, 32'(in_rdy), 32'd0);
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk({tag, ".no_pass"}, 32'(in_rdy), 32'd0);
    @(negedge clk);
    out_rdy = 1'b0;
    chk({tag, ".back_rdy"}, 32'(in_rdy), 32'd1);
    chk({tag, ".back_val"}, 32'(out_val), 32'd0);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [15:0] rexp;
    reset_n   = 1'b0;
    in_val    = 1'b0;
    in0       = '0;
    in1       = '0;
    is_signed = 1'b0;
    out_rdy   = 1'b0;
    #2;
    chk("rst.in_rdy", 32'(in_rdy), 32'd1);
    chk("rst.out_val", 32'(out_val), 32'd0);
    chk("rst.out", 32'(out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst.in_rdy", 32'(in_rdy), 32'd1);
    chk("post_rst.out_val", 32'(out_val), 32'd0);
    chk("post_rst.out", 32'(out), 32'd0);

    do_mul("m3x5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
    do_mul("s80x80",  8'h80, 8'h80, 1'b1, 16'h4000, 0);
    do_mul("u80x80",  8'h80, 8'h80, 1'b0, 16'h4000, 0);
    do_mul("uFFxFF",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    do_mul("s80x01",  8'h80, 8'h01, 1'b1, 16'hFF80, 0);
    do_mul("s0xm7",   8'h00, 8'hF9, 1'b1, 16'h0000, 0);
    do_mul("sm7x0",   8'hF9, 8'h00, 1'b1, 16'h0000, 0);
    do_mul("u12x13",  8'h0C, 8'h0D, 1'b0, 16'h009C, 5);
    do_mul("s7Fx81",  8'h7F, 8'h81, 1'b1, 16'hC0FF, 0);
    do_mul("sFFxFF",  8'hFF, 8'hFF, 1'b1, 16'h0001, 2);
    do_mul("u100x1",  8'h64, 8'h01, 1'b0, 16'h0064, 0);
    do_mul("s7Fx7F",  8'h7F, 8'h7F, 1'b1, 16'h3F01, 0);

    @(negedge clk);
    in_val = 1'b1;
    in0 = 8'h55;
    in1 = 8'hAA;
    is_signed = 1'b0;
    @(negedge clk);
    in_val = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst.in_rdy", 32'(in_rdy), 32'd1);
    chk("midrst.out_val", 32'(out_val), 32'd0);
    chk("midrst.out", 32'(out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst.rel_rdy", 32'(in_rdy), 32'd1);
    do_mul("u7x7", 8'h07, 8'h07, 1'b0, 16'd49, 0);

    for (int t = 0; t < 200; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (rs)
        rexp = 16'($signed(ra) * $signed(rb));
      else
        rexp = 16'(ra) * 16'(rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_mul("rand", ra, rb, rs, rexp,
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
